// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a mid-bit sampling FSM and a one-entry valid/ready holding register.
// Latency: from a start-bit falling edge on rx at cycle t, valid rises at t + 2 + HALF + 1 + 9*CLOCKS_PER_BIT + 1.
// Backpressure: one byte is held until it is consumed. A byte that completes while the holder is full and not being consumed is dropped and flagged on overrun.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   rx         asynchronous serial line, idle high, LSB first
//   data       received byte, stable while valid=1
//   valid      data holds an unconsumed byte
//   ready      consumer accepts data when valid && ready
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a byte is dropped because the holder is full

module uart_rx #(
  parameter int CLOCK_RATE     = 100_000_000,
  parameter int BAUD_RATE      = 115_200,
  // Must be >= 4 so that the half-bit and full-bit sample points are distinct.
  parameter int CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  // The start bit is confirmed at its mid-point. Every later sample is one full
  // bit period after the previous one, so all samples land mid-bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLOCKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  // Synchroniser. Both flops reset high so that reset never looks like a start bit.
  logic rx_meta_q;
  logic rx_s_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             frame_err_q;

  // Holding register and handshake.
  logic [7:0] data_q,    data_d;
  logic       valid_q,   valid_d;
  logic       overrun_q, overrun_d;

  logic stop_sample;
  logic deliver;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The stop bit is sampled on this cycle. A high sample yields a good byte.
  assign stop_sample = (state_q == ST_STOP) && (cnt_q == CNT_LAST);
  assign deliver     = stop_sample && rx_s_q;

  // Receive FSM. The frame_err pulse is registered here alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              // The line went high again before mid-bit, so this was a glitch.
              state_q <= ST_IDLE;
            end else begin
              state_q   <= ST_DATA;
              bit_idx_q <= 3'd0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q            <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            // Returning to IDLE mid-stop-bit lets a back-to-back start bit be
            // caught and gives about half a bit of slack for baud mismatch.
            if (rx_s_q) begin
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WAIT_HIGH: begin
          // Wait here so that a held-low (break) line reports only one error.
          cnt_q <= '0;
          if (rx_s_q) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Holding register. A delivery may coincide with the consumption of the
  // previous byte, in which case the new byte replaces it without a gap.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (deliver) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
